// File: rtl/apb_requester.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// apb_requester
//
// APB4 initiator. It takes one request on a valid/ready channel, runs it as an
// APB setup/access transfer, and holds the result on a response channel until
// the response is consumed. Only one transfer is in flight at a time.
//
// Optional feature macro: APB_REQUESTER_TIMEOUT_EN
//   When defined, a watchdog aborts an access after TIMEOUT_CYCLES wait states
//   and reports rsp_slverr = 1 and rsp_timeout = 1. When undefined, an access
//   waits for pready indefinitely and rsp_timeout is tied low.
//
// Parameters:
//   ADDR_WIDTH      width of req_addr / paddr (byte address, at least 3)
//   DATA_WIDTH      data width; strobes are DATA_WIDTH/8 bits
//   TIMEOUT_CYCLES  wait-state limit for the watchdog (1..65535)
//
// Ports:
//   clk, reset_n             clock (also pclk) and async active-low reset
//   req_valid / req_ready    request handshake
//   req_write, req_addr,
//   req_wdata, req_strb      request payload
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_slverr,
//   rsp_timeout              response payload (rdata is 0 for writes)
//   psel, penable, pwrite,
//   paddr, pwdata, pstrb     APB requester outputs
//   pready, pslverr, prdata  APB completer inputs
// -----------------------------------------------------------------------------
module apb_requester #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset_n,
   // request channel
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_strb,
   // response channel
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_slverr,
   output logic                    rsp_timeout,
   // APB
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic                    pready,
   input  logic                    pslverr,
   input  logic [DATA_WIDTH-1:0]   prdata
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t                  state_q, state_d;

   logic                    psel_d, penable_d, pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_d;
   logic [STRB_WIDTH-1:0]   pstrb_d;
   logic                    rsp_valid_d, rsp_slverr_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_d;

   // The two low address bits never reach the bus (transfers are word
   // aligned); the reduction keeps them visibly consumed.
   logic                    addr_lsb_unused;
   assign addr_lsb_unused = ^req_addr[1:0];

`ifdef APB_REQUESTER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0]             wait_cnt_q, wait_cnt_d;
   logic                    rsp_timeout_d;
`else
   // The limit is only consulted when the watchdog is built in.
   localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

   assign rsp_timeout = 1'b0;
`endif

   // Only combinational output: the request is taken only in IDLE, and never
   // while reset is asserted.
   assign req_ready = reset_n && (state_q == IDLE);

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a hold/default value before the case statement
      // so no path leaves it unassigned, which would infer a latch.
      state_d      = state_q;
      psel_d       = psel;
      penable_d    = penable;
      pwrite_d     = pwrite;
      paddr_d      = paddr;
      pwdata_d     = pwdata;
      pstrb_d      = pstrb;
      rsp_valid_d  = rsp_valid;
      rsp_rdata_d  = rsp_rdata;
      rsp_slverr_d = rsp_slverr;
`ifdef APB_REQUESTER_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
      rsp_timeout_d = rsp_timeout;
`endif

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d  = SETUP;
               psel_d   = 1'b1;
               pwrite_d = req_write;
               paddr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
               pwdata_d = req_wdata;
               // Reads carry no byte enables on the bus.
               pstrb_d  = req_write ? req_strb : '0;
            end
         end

         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef APB_REQUESTER_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end

         ACCESS: begin
            if (pready) begin
               // Completion has priority over a watchdog expiring on this edge.
               state_d      = RESP;
               psel_d       = 1'b0;
               penable_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_rdata_d  = pwrite ? '0 : prdata;
               rsp_slverr_d = pslverr;
`ifdef APB_REQUESTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
            end else if (wait_cnt_q == TIMEOUT_LIMIT) begin
               state_d       = RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
`endif
            end
         end

         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         pstrb      <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else begin
         state_q    <= state_d;
         psel       <= psel_d;
         penable    <= penable_d;
         pwrite     <= pwrite_d;
         paddr      <= paddr_d;
         pwdata     <= pwdata_d;
         pstrb      <= pstrb_d;
         rsp_valid  <= rsp_valid_d;
         rsp_rdata  <= rsp_rdata_d;
         rsp_slverr <= rsp_slverr_d;
      end
   end

`ifdef APB_REQUESTER_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q  <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         rsp_timeout <= rsp_timeout_d;
      end
   end
`endif

endmodule

// File: tb/tb_apb_requester.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_apb_requester
//
// Self-checking bench for apb_requester. A transaction-level model predicts,
// from the acceptance edge and the number of wait states each transfer gets,
// which cycles psel / penable / rsp_valid must be high and what the bus and
// response payloads must hold. A compare process checks the DUT against that
// model on every falling edge; directed scenarios add hand-computed literal
// expectations. Build with +define+APB_REQUESTER_TIMEOUT_EN to add the
// watchdog scenarios (TIMEOUT_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_apb_requester;

   localparam int AW     = 12;
   localparam int DW     = 32;
   localparam int SW     = DW / 8;
   localparam int TO_CYC = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [SW-1:0] req_strb = '0;
   logic          rsp_ready = 1'b0;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;
   logic [DW-1:0] prdata = '0;

   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic          rsp_timeout;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;

   apb_requester #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_strb   (req_strb),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_slverr (rsp_slverr),
      .rsp_timeout(rsp_timeout),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .pstrb      (pstrb),
      .pready     (pready),
      .pslverr    (pslverr),
      .prdata     (prdata)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Check bookkeeping
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Transaction-level reference model
   //   t0 = edge index at which the request is taken
   //   tc = edge index of completion = t0 + 2 + effective wait states
   //   psel high after edges t0..tc-1, penable after t0+1..tc-1,
   //   rsp_valid from edge tc until the first later edge with rsp_ready.
   // ---------------------------------------------------------------------------
   int            nx_waits = 0;          // slave behaviour for the next request
   logic [DW-1:0] nx_rdata = '0;
   logic          nx_err   = 1'b0;

   int            n = 0;                 // rising-edge index
   bit            busy = 1'b0;
   int            t0 = 0, tc = 0;
   int            cur_waits = 0;
   logic [DW-1:0] cur_rdata = '0;
   logic          cur_err = 1'b0;
   logic          m_pwrite = 1'b0;
   logic [AW-1:0] m_paddr = '0;
   logic [DW-1:0] m_pwdata = '0;
   logic [SW-1:0] m_pstrb = '0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_err = 1'b0, m_to = 1'b0;
   int            m_eff = 0;
   bit            m_abort = 1'b0;
   int            accepts = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy     = 1'b0;
         m_pwrite = 1'b0;
         m_paddr  = '0;
         m_pwdata = '0;
         m_pstrb  = '0;
         m_rdata  = '0;
         m_err    = 1'b0;
         m_to     = 1'b0;
      end else begin
         n++;
         if (busy) begin
            if (n > tc && rsp_ready) busy = 1'b0;
         end else if (req_valid) begin
            busy      = 1'b1;
            accepts++;
            t0        = n;
            cur_waits = nx_waits;
            cur_rdata = nx_rdata;
            cur_err   = nx_err;
            m_pwrite  = req_write;
            m_paddr   = {req_addr[AW-1:2], 2'b00};
            m_pwdata  = req_wdata;
            m_pstrb   = req_write ? req_strb : '0;
            m_eff     = nx_waits;
            m_abort   = 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
            if (nx_waits > TO_CYC) begin
               m_eff   = TO_CYC;
               m_abort = 1'b1;
            end
`endif
            tc      = t0 + 2 + m_eff;
            m_to    = m_abort;
            m_err   = m_abort ? 1'b1 : nx_err;
            m_rdata = (m_abort || req_write) ? '0 : nx_rdata;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // APB completer: ready after cur_waits access cycles; noise otherwise
   // ---------------------------------------------------------------------------
   int acc_cnt = 0;

   always @(posedge clk) begin
      #1;
      if (psel && penable) begin
         pready  = (acc_cnt >= cur_waits);
         prdata  = pready ? cur_rdata : $urandom;
         pslverr = pready ? cur_err : 1'($urandom_range(0, 1));
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         pready  = 1'($urandom_range(0, 1));
         prdata  = $urandom;
         pslverr = 1'($urandom_range(0, 1));
      end
   end

   // rsp_ready driver: 0 = held low, 1 = held high, 2 = random per cycle
   int rsp_mode = 1;

   always @(posedge clk) begin
      #2;
      case (rsp_mode)
         0:       rsp_ready = 1'b0;
         1:       rsp_ready = 1'b1;
         default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------------------------------------------------------------------
   // Compare process
   // ---------------------------------------------------------------------------
   bit cmp_on = 1'b0;

   always @(negedge clk) begin
      if (cmp_on) begin
         check("cmp_req_ready", req_ready, reset_n && !busy);
         check("cmp_psel",      psel,      busy && n < tc);
         check("cmp_penable",   penable,   busy && n >= t0 + 1 && n < tc);
         check("cmp_rsp_valid", rsp_valid, busy && n >= tc);
         check("cmp_pwrite",    pwrite,    m_pwrite);
         check("cmp_paddr",     paddr,     m_paddr);
         check("cmp_pwdata",    pwdata,    m_pwdata);
         check("cmp_pstrb",     pstrb,     m_pstrb);
         if (busy && n >= tc) begin
            check("cmp_rsp_rdata",   rsp_rdata,   m_rdata);
            check("cmp_rsp_slverr",  rsp_slverr,  m_err);
            check("cmp_rsp_timeout", rsp_timeout, m_to);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor for directed literal checks
   // ---------------------------------------------------------------------------
   int            psel_cyc, pen_cyc, rsp_cyc, rdy_in_rsp, paddr_moves;
   int            psel_rise_n, prev_rise_n, rsp_rise_n;
   bit            psel_q = 1'b0, rsp_q = 1'b0;
   logic [AW-1:0] rise_paddr;
   logic          rise_pwrite;
   logic [SW-1:0] rise_pstrb;
   logic [DW-1:0] last_rdata;
   logic          last_err, last_to;

   task automatic clr_mon();
      psel_cyc    = 0;
      pen_cyc     = 0;
      rsp_cyc     = 0;
      rdy_in_rsp  = 0;
      paddr_moves = 0;
   endtask

   always @(negedge clk) begin
      if (psel) begin
         psel_cyc++;
         if (!psel_q) begin
            prev_rise_n = psel_rise_n;
            psel_rise_n = n;
            rise_paddr  = paddr;
            rise_pwrite = pwrite;
            rise_pstrb  = pstrb;
         end else if (paddr !== rise_paddr) begin
            paddr_moves++;
         end
      end
      if (penable) pen_cyc++;
      if (rsp_valid) begin
         rsp_cyc++;
         if (req_ready) rdy_in_rsp++;
         if (!rsp_q) rsp_rise_n = n;
         last_rdata = rsp_rdata;
         last_err   = rsp_slverr;
         last_to    = rsp_timeout;
      end
      psel_q = psel;
      rsp_q  = rsp_valid;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called 1 ns after a rising edge)
   // ---------------------------------------------------------------------------
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int w, input logic [DW-1:0] rd,
                        input bit e);
      int base;
      int k;
      base      = accepts;
      k         = 0;
      nx_waits  = w;
      nx_rdata  = rd;
      nx_err    = e;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_strb  = s;
      req_valid = 1'b1;
      while (accepts == base && k < 400) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("request_taken", accepts - base, 1);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 400) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("idle_reached", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   initial begin
      int k;

      // Reset state
      rsp_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready",   req_ready,   1'b0);
      check("rst_psel",        psel,        1'b0);
      check("rst_penable",     penable,     1'b0);
      check("rst_pwrite",      pwrite,      1'b0);
      check("rst_paddr",       paddr,       '0);
      check("rst_pwdata",      pwdata,      '0);
      check("rst_pstrb",       pstrb,       '0);
      check("rst_rsp_valid",   rsp_valid,   1'b0);
      check("rst_rsp_rdata",   rsp_rdata,   '0);
      check("rst_rsp_slverr",  rsp_slverr,  1'b0);
      check("rst_rsp_timeout", rsp_timeout, 1'b0);
      #2 reset_n = 1'b1;
      #1 check("req_ready_after_reset", req_ready, 1'b1);
      cmp_on = 1'b1;
      @(posedge clk);
      #1;

      // Write, zero wait states
      clr_mon();
      issue(1'b1, 12'h004, 32'h0000_00A5, 4'hF, 0, '0, 1'b0);
      wait_idle();
      check("wr_psel_cycles",    psel_cyc, 2);
      check("wr_penable_cycles", pen_cyc,  1);
      check("wr_pwrite",         rise_pwrite, 1'b1);
      check("wr_pstrb",          rise_pstrb,  4'hF);
      check("wr_paddr",          rise_paddr,  12'h004);
      check("wr_rsp_latency",    rsp_rise_n - psel_rise_n, 2);
      check("wr_rsp_rdata",      last_rdata, 32'h0);
      check("wr_rsp_slverr",     last_err,   1'b0);

      // Read, three wait states, unaligned address and stray strobes
      clr_mon();
      issue(1'b0, 12'h013, 32'hFFFF_0000, 4'hF, 3, 32'h1234_5678, 1'b0);
      wait_idle();
      check("rd_psel_cycles",  psel_cyc, 5);
      check("rd_penable_cycles", pen_cyc, 4);
      check("rd_pstrb",        rise_pstrb, 4'h0);
      check("rd_paddr",        rise_paddr, 12'h010);
      check("rd_paddr_stable", paddr_moves, 0);
      check("rd_rsp_rdata",    last_rdata, 32'h1234_5678);
      check("rd_rsp_latency",  rsp_rise_n - psel_rise_n, 5);

      // Slave error with five cycles of response backpressure
      rsp_mode = 0;
      clr_mon();
      issue(1'b1, 12'h020, 32'hDEAD_BEEF, 4'h3, 1, '0, 1'b1);
      k = 0;
      while (!(busy && n >= tc) && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rsp_mode = 1;
      @(posedge clk);
      #1;
      check("bp_idle_req_ready", req_ready, 1'b1);
      check("bp_idle_rsp_valid", rsp_valid, 1'b0);
      check("bp_rsp_cycles",     rsp_cyc,   5);
      check("bp_req_ready_low",  rdy_in_rsp, 0);
      check("bp_rsp_slverr",     last_err,  1'b1);
      check("bp_rsp_rdata",      last_rdata, 32'h0);

      // Back-to-back requests with rsp_ready held high
      clr_mon();
      issue(1'b1, 12'h008, 32'h0BAD_F00D, 4'hC, 0, '0, 1'b0);
      issue(1'b0, 12'h00C, 32'h0, 4'h0, 0, 32'hCAFE_0001, 1'b0);
      wait_idle();
      check("b2b_psel_spacing", psel_rise_n - prev_rise_n, 4);
      check("b2b_psel_cycles",  psel_cyc, 4);
      check("b2b_second_paddr", rise_paddr, 12'h00C);
      check("b2b_rsp_rdata",    last_rdata, 32'hCAFE_0001);

      // Reset asserted during a wait state
      issue(1'b0, 12'h030, 32'h0, 4'h0, 20, 32'h5555_AAAA, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_psel",      psel,      1'b0);
      check("mid_rst_penable",   penable,   1'b0);
      check("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check("mid_rst_req_ready", req_ready, 1'b0);
      check("mid_rst_paddr",     paddr,     '0);
      @(posedge clk);
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      clr_mon();
      repeat (30) begin
         @(posedge clk);
         #1;
      end
      check("no_rsp_after_reset", rsp_cyc, 0);
      issue(1'b1, 12'h040, 32'h7777_0001, 4'h1, 2, '0, 1'b0);
      wait_idle();
      check("post_rst_rsp_cycles", rsp_cyc, 1);
      check("post_rst_slverr",     last_err, 1'b0);

`ifdef APB_REQUESTER_TIMEOUT_EN
      // Watchdog: pready stuck low aborts after TO_CYC wait cycles
      clr_mon();
      issue(1'b0, 12'h050, 32'h0, 4'h0, 1000, 32'h1111_1111, 1'b0);
      wait_idle();
      check("to_psel_cycles", psel_cyc, 6);
      check("to_rsp_timeout", last_to,  1'b1);
      check("to_rsp_slverr",  last_err, 1'b1);
      check("to_rsp_rdata",   last_rdata, 32'h0);

      // pready arrives on the deciding edge: completion wins
      clr_mon();
      issue(1'b0, 12'h054, 32'h0, 4'h0, TO_CYC, 32'h2222_3333, 1'b0);
      wait_idle();
      check("to_edge_psel_cycles", psel_cyc, 6);
      check("to_edge_rsp_timeout", last_to,  1'b0);
      check("to_edge_rsp_slverr",  last_err, 1'b0);
      check("to_edge_rsp_rdata",   last_rdata, 32'h2222_3333);
`endif

      // Randomised traffic with random response backpressure
      rsp_mode = 2;
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         issue(1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom),
               int'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1)));
      end
      rsp_mode = 1;
      wait_idle();
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB4 initiator that turns a simple valid/ready request into a complete APB setup/access transfer and returns the result on a held response channel. It sits opposite the UART's APB register slave: firmware-model logic, bridges and self-checking harnesses use it to program and poll the UART on the same `clk`. One outstanding transfer at a time, with no pipelining across transfers.

## Interface
- `ADDR_WIDTH`, default 12: width of `req_addr`/`paddr`.
- `DATA_WIDTH`, default 32: data width; `pstrb` is `DATA_WIDTH/8` bits.
- `TIMEOUT_CYCLES`, default 255: maximum number of wait-state cycles before abort. Used only with `APB_REQUESTER_TIMEOUT_EN`. Legal range 1..65535.

Ports:
- `clk` input 1: the only clock; also drives the APB side (pclk = clk).
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when high together with `req_valid`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_WIDTH: byte address.
- `req_wdata` input DATA_WIDTH: write data.
- `req_strb` input DATA_WIDTH/8: write byte strobes.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: response consumed.
- `rsp_rdata` output DATA_WIDTH: read data; 0 for writes.
- `rsp_slverr` output 1: slave error or timeout.
- `rsp_timeout` output 1: transfer was aborted by the watchdog.
- `psel`, `penable`, `pwrite` output 1 each: APB controls.
- `paddr` output ADDR_WIDTH: APB address.
- `pwdata` output DATA_WIDTH: APB write data.
- `pstrb` output DATA_WIDTH/8: APB strobes.
- `pready`, `pslverr` input 1 each: APB completer status.
- `prdata` input DATA_WIDTH: APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1, gated to 0 while `reset_n` = 0.
  - When `req_valid` = 1, register `req_*` into the APB outputs and go to SETUP.
- Address and strobes:
  - `paddr[1:0]` is forced to 0 (word-aligned); the remaining bits come from `req_addr`.
  - On a read, `pstrb` is driven to 0 regardless of `req_strb`.
- SETUP: `psel` = 1, `penable` = 0. Unconditionally go to ACCESS.
- ACCESS: `psel` = 1, `penable` = 1. At a clock edge with `pready` = 1:
  - capture `prdata` (reads only) into `rsp_rdata`, and capture `pslverr`;
  - drop `psel` and `penable`;
  - go to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_*` are held stable until a `rsp_valid && rsp_ready` edge, then return to IDLE.
  - `req_ready` = 0 throughout RESP.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are stable from SETUP through the completion edge, and retain their last values while idle.
- `pslverr` and `prdata` are ignored when `pready` = 0.
- Reset mid-transfer: all outputs go immediately to their reset values. The interrupted transfer is dropped and no response is produced.
- Reset values: `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata`, `pstrb` = 0; `rsp_valid`, `rsp_slverr`, `rsp_timeout` = 0; `rsp_rdata` = 0; `req_ready` = 0.

## Timing
- All outputs are registered except `req_ready`, which decodes the state.
- Edge sequence, with the request accepted at edge E0:
  - `psel` rises after E0;
  - `penable` rises after E0+1;
  - a zero-wait completion happens at E0+2, and `rsp_valid` rises after E0+2.
- Each cycle with `pready` = 0 in ACCESS adds exactly one cycle.
- Minimum request-to-request spacing is 4 cycles when `rsp_ready` is held at 1.
- A request presented while the block is not in IDLE is not accepted; it stays pending on the request channel.

## Configuration
- `APB_REQUESTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready` = 0.
  - When the counter equals `TIMEOUT_CYCLES` and `pready` is still 0, the transfer is aborted: `psel`/`penable` drop, and the block goes to RESP with `rsp_slverr` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - If `pready` = 1 on that same edge, the completion wins and `rsp_timeout` = 0.
- `APB_REQUESTER_TIMEOUT_EN` not defined: ACCESS waits indefinitely, and `rsp_timeout` is tied to 0.

## Test plan
- Write, zero wait: req write addr 0x004, wdata 0x0000_00A5, strb 0xF.
  - Required: `psel` high for 2 cycles, `penable` high for 1; `pwrite` = 1, `pstrb` = 0xF.
  - Response: `rsp_valid` after E0+2 with `rsp_slverr` = 0, `rsp_rdata` = 0.
- Read with 3 wait states: slave holds `pready` = 0 for 3 ACCESS cycles and then returns `prdata` 0x1234_5678.
  - Required: `rsp_rdata` = 0x1234_5678, `pstrb` = 0, `paddr` stable for all 5 APB cycles.
- Slave error and backpressure: `pslverr` = 1 on completion and `rsp_ready` held 0 for 5 cycles.
  - Required: `rsp_valid`/`rsp_slverr` = 1 held for 5 cycles; `req_ready` = 0 throughout; IDLE the cycle after the handshake.
- Back-to-back with `rsp_ready` = 1: two requests (write 0x008 then read 0x00C).
  - Required: the second `psel` rises exactly 4 cycles after the first; no overlap.
- Reset mid-ACCESS: `reset_n` low during a wait state.
  - Required: `psel` = `penable` = `rsp_valid` = 0 immediately; no response after release; the next request completes normally.
- With `APB_REQUESTER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, `pready` stuck at 0.
  - Required: abort after 4 wait cycles with `rsp_slverr` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - Repeat with `pready` = 1 on the 4th wait cycle: normal completion, `rsp_timeout` = 0.
